// File: rtl/prng_pkg.sv
// Shared constants and helpers for the lane-parallel Galois LFSR stream generator:
// feedback taps, golden-ratio lane spreading, default seed and FSM states.
package prng_pkg;

    localparam logic [63:0] GOLDEN       = 64'h9E37_79B9_7F4A_7C15;
    localparam logic [63:0] DEFAULT_SEED = 64'h0000_0000_0000_0001;

    typedef enum logic [0:0] {
        ST_WARMUP = 1'b0,
        ST_RUN    = 1'b1
    } prng_state_e;

    // Maximal-length right-shift Galois feedback mask for each supported width.
    function automatic logic [63:0] lfsr_taps(input int w);
        logic [63:0] t;
        case (w)
            32'sd16: t = 64'h0000_0000_0000_B400;
            32'sd24: t = 64'h0000_0000_00E1_0000;
            32'sd32: t = 64'h0000_0000_8020_0003;
            32'sd64: t = 64'hD800_0000_0000_0000;
            default: t = 64'h0000_0000_8020_0003;
        endcase
        return t;
    endfunction

    function automatic logic [63:0] width_mask(input int w);
        logic [63:0] m;
        if (w >= 32'sd64) begin
            m = {64{1'b1}};
        end else begin
            m = (64'd1 << w) - 64'd1;
        end
        return m;
    endfunction

    // The golden constant is narrowed by keeping its most significant bits.
    function automatic logic [63:0] golden_trunc(input int w);
        return GOLDEN >> (32'sd64 - w);
    endfunction

    // Lane k seed; an all-zero LFSR would lock up, so zero is replaced by one.
    function automatic logic [63:0] lane_seed(input logic [63:0] base, input int k, input int w);
        logic [63:0] s;
        s = (base ^ (64'(k) * golden_trunc(w))) & width_mask(w);
        if (s == 64'd0) begin
            s = 64'd1;
        end else begin
            s = s;
        end
        return s;
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// One generator lane: a right-shifting Galois LFSR with load, step and hold.
module lfsr_core
    import prng_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] TAPS       = WIDTH'(lfsr_taps(WIDTH)),
    parameter logic [WIDTH-1:0] RESET_SEED = WIDTH'(DEFAULT_SEED)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             step,
    output logic [WIDTH-1:0] state
);

    logic [WIDTH-1:0] state_r;
    logic [WIDTH-1:0] stepped_s;

    // Next LFSR value if this lane is advanced.
    always_comb begin
        stepped_s = state_r >> 1;
        if (state_r[0]) begin
            stepped_s = (state_r >> 1) ^ TAPS;
        end else begin
            stepped_s = state_r >> 1;
        end
    end

    // Lane state register; reseeding wins over stepping.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r <= RESET_SEED;
        end else if (load) begin
            state_r <= load_value;
        end else if (step) begin
            state_r <= stepped_s;
        end else begin
            state_r <= state_r;
        end
    end

    assign state = state_r;

endmodule

// File: rtl/lfsr_prng_stream.sv
// Multi-lane LFSR pseudo-random word stream with warm-up and valid/ready output.
// Optional macro LFSR_PRNG_SCALE_EN adds a scale input mapping each lane into [0, scale).
module lfsr_prng_stream
    import prng_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int LANES  = 4,
    parameter int WARMUP = 64
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   seed_load,
    input  logic [WIDTH-1:0]       seed,
    input  logic                   enable,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_data,
`ifdef LFSR_PRNG_SCALE_EN
    input  logic [WIDTH-1:0]       scale,
`endif
    output logic                   busy
);

    localparam logic [10:0] WARM_LAST = (WARMUP > 32'sd0) ? 11'(WARMUP - 32'sd1) : 11'd0;

    prng_state_e            state_r;
    prng_state_e            state_nxt_s;
    logic [10:0]            warm_cnt_r;
    logic [10:0]            warm_cnt_nxt_s;
    logic                   step_s;
    logic                   emit_s;
    logic                   drain_s;
    logic                   out_valid_r;
    logic                   busy_r;
    logic [LANES*WIDTH-1:0] out_data_r;
    logic [LANES*WIDTH-1:0] word_s;
    logic [WIDTH-1:0]       base_s;
    logic [WIDTH-1:0]       lane_seed_s  [LANES];
    logic [WIDTH-1:0]       lane_state_s [LANES];

    assign base_s = (seed == '0) ? WIDTH'(DEFAULT_SEED) : seed;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        localparam logic [WIDTH-1:0] RST_SEED = WIDTH'(lane_seed(DEFAULT_SEED, k, WIDTH));

        assign lane_seed_s[k] = WIDTH'(lane_seed(64'(base_s), k, WIDTH));

        lfsr_core #(
            .WIDTH      (WIDTH),
            .TAPS       (WIDTH'(lfsr_taps(WIDTH))),
            .RESET_SEED (RST_SEED)
        ) u_core (
            .clk        (clk),
            .resetn     (resetn),
            .load       (seed_load),
            .load_value (lane_seed_s[k]),
            .step       (step_s),
            .state      (lane_state_s[k])
        );

`ifdef LFSR_PRNG_SCALE_EN
        logic [2*WIDTH-1:0] prod_s;
        assign prod_s = {{WIDTH{1'b0}}, lane_state_s[k]} * {{WIDTH{1'b0}}, scale};
        assign word_s[k*WIDTH +: WIDTH] = prod_s[2*WIDTH-1:WIDTH];
`else
        assign word_s[k*WIDTH +: WIDTH] = lane_state_s[k];
`endif
    end

    // FSM state and warm-up counter.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r    <= ST_WARMUP;
            warm_cnt_r <= 11'd0;
        end else begin
            state_r    <= state_nxt_s;
            warm_cnt_r <= warm_cnt_nxt_s;
        end
    end

    // Next state and lane/output control; a reseed overrides everything.
    always_comb begin
        state_nxt_s    = state_r;
        warm_cnt_nxt_s = warm_cnt_r;
        step_s         = 1'b0;
        emit_s         = 1'b0;
        drain_s        = 1'b0;
        if (seed_load) begin
            state_nxt_s    = ST_WARMUP;
            warm_cnt_nxt_s = 11'd0;
        end else begin
            case (state_r)
                ST_WARMUP: begin
                    if (WARMUP == 32'sd0) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        step_s = 1'b1;
                        if (warm_cnt_r == WARM_LAST) begin
                            state_nxt_s    = ST_RUN;
                            warm_cnt_nxt_s = 11'd0;
                        end else begin
                            warm_cnt_nxt_s = warm_cnt_r + 11'd1;
                        end
                    end
                end
                ST_RUN: begin
                    // A slot is free when nothing is held or the held word leaves now.
                    if ((!out_valid_r || out_ready) && enable) begin
                        emit_s = 1'b1;
                        step_s = 1'b1;
                    end else if (out_valid_r && out_ready) begin
                        drain_s = 1'b1;
                    end else begin
                        drain_s = 1'b0;
                    end
                end
                default: begin
                    state_nxt_s    = ST_WARMUP;
                    warm_cnt_nxt_s = 11'd0;
                end
            endcase
        end
    end

    // Output word, valid flag and busy flag.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            busy_r      <= 1'b0;
        end else begin
            busy_r <= (state_nxt_s == ST_WARMUP);
            if (seed_load) begin
                out_valid_r <= 1'b0;
            end else if (emit_s) begin
                out_valid_r <= 1'b1;
                out_data_r  <= word_s;
            end else if (drain_s) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_lfsr_prng_stream.sv
// Scoreboard bench: a 2-lane 32-bit instance without warm-up for stream checks and a
// 1-lane 16-bit instance with a short warm-up for busy timing, reseeding and period.
module tb_lfsr_prng_stream;

    logic        clk = 1'b0;
    logic        resetn;
    logic        seed_load0, enable0, ready0, valid0, busy0;
    logic [31:0] seed0;
    logic [63:0] data0;
    logic        seed_load1, enable1, ready1, valid1, busy1;
    logic [15:0] seed1, data1;
    logic [31:0] scale0 = 32'd100;
    logic [15:0] scale1 = 16'hFFFF;

    int vectors     = 0;
    int miscompares = 0;
    logic [63:0] sb [$];

    always #5 clk = ~clk;

    lfsr_prng_stream #(.WIDTH(32), .LANES(2), .WARMUP(0)) dut0 (
        .clk(clk), .resetn(resetn), .seed_load(seed_load0), .seed(seed0),
        .enable(enable0), .out_valid(valid0), .out_ready(ready0), .out_data(data0),
`ifdef LFSR_PRNG_SCALE_EN
        .scale(scale0),
`endif
        .busy(busy0)
    );

    lfsr_prng_stream #(.WIDTH(16), .LANES(1), .WARMUP(3)) dut1 (
        .clk(clk), .resetn(resetn), .seed_load(seed_load1), .seed(seed1),
        .enable(enable1), .out_valid(valid1), .out_ready(ready1), .out_data(data1),
`ifdef LFSR_PRNG_SCALE_EN
        .scale(scale1),
`endif
        .busy(busy1)
    );

    function automatic logic [31:0] m_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    function automatic logic [31:0] m_emit(input logic [31:0] s);
`ifdef LFSR_PRNG_SCALE_EN
        logic [63:0] p;
        p = {32'd0, s} * 64'd100;
        return p[63:32];
`else
        return s;
`endif
    endfunction

    function automatic logic [15:0] m_emit16(input logic [15:0] s);
`ifdef LFSR_PRNG_SCALE_EN
        logic [31:0] p;
        p = {16'd0, s} * 32'h0000_FFFF;
        return p[31:16];
`else
        return s;
`endif
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic push_lanes(input logic [31:0] s0, input logic [31:0] s1, input int n);
        logic [31:0] a, b;
        a = s0;
        b = s1;
        for (int i = 0; i < n; i++) begin
            sb.push_back({m_emit(b), m_emit(a)});
            a = m_step(a);
            b = m_step(b);
        end
    endtask

    task automatic push_base(input logic [31:0] base, input int n);
        logic [31:0] s0, s1;
        s0 = (base == 32'd0) ? 32'd1 : base;
        s1 = s0 ^ 32'h9E37_79B9;
        if (s1 == 32'd0) s1 = 32'd1;
        push_lanes(s0, s1, n);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain0(input string name);
        for (int i = 0; i < 200 && sb.size() != 0; i++) tick();
        if (sb.size() != 0) begin
            check({name, "_timeout"}, 64'(sb.size()), 64'd0);
            sb.delete();
        end
        enable0 = 1'b0;
        ready0  = 1'b0;
    endtask

    task automatic reseed0(input logic [31:0] s, input string name);
        seed0 = s;
        seed_load0 = 1'b1;
        tick();
        seed_load0 = 1'b0;
        check({name, "_valid_low"}, 64'(valid0), 64'd0);
        check({name, "_busy_high"}, 64'(busy0), 64'd1);
    endtask

    task automatic busy_count1(output int n);
        n = 0;
        for (int i = 0; i < 50 && busy1; i++) begin
            n++;
            tick();
        end
    endtask

    task automatic wait_valid1(input string name);
        for (int i = 0; i < 20 && !valid1; i++) tick();
        if (!valid1) check({name, "_valid_timeout"}, 64'(valid1), 64'd1);
    endtask

    // Monitor: every accepted word of dut0 is popped from the scoreboard and compared.
    always @(negedge clk) begin
        if (resetn && valid0 && ready0 && !seed_load0) begin
            if (sb.size() == 0) begin
                check("unexpected_word", data0, 64'd0);
            end else begin
                check("stream_word", data0, sb.pop_front());
            end
        end
    end

    initial begin
        int n;
        logic [15:0] en_pat;
        en_pat = 16'b1011_0010_1100_1001;
        resetn = 1'b0;
        seed_load0 = 1'b0; enable0 = 1'b0; ready0 = 1'b0; seed0 = 32'd0;
        seed_load1 = 1'b0; enable1 = 1'b0; ready1 = 1'b0; seed1 = 16'd0;
        repeat (3) tick();
        check("rst_valid0", 64'(valid0), 64'd0);
        check("rst_data0", data0, 64'd0);
        check("rst_busy0", 64'(busy0), 64'd0);
        check("rst_valid1", 64'(valid1), 64'd0);
        check("rst_data1", 64'(data1), 64'd0);
        check("rst_busy1", 64'(busy1), 64'd0);

        // Stream straight out of reset uses the base-1 seeds.
        push_base(32'd1, 4);
        enable0 = 1'b1; ready0 = 1'b1;
        resetn = 1'b1;
        drain0("reset_stream");

        // Hand-computed first words for seed 1.
        reseed0(32'd1, "seed1");
        sb.push_back({m_emit(32'h9E37_79B8), m_emit(32'h0000_0001)});
        sb.push_back({m_emit(32'h4F1B_BCDC), m_emit(32'h8020_0003)});
        sb.push_back({m_emit(32'h278D_DE6E), m_emit(32'hC030_0002)});
        push_lanes(m_step(32'hC030_0002), m_step(32'h278D_DE6E), 5);
        enable0 = 1'b1; ready0 = 1'b1;
        drain0("seed1");

        // Seed 0 behaves as seed 1.
        reseed0(32'd0, "seed0");
        push_base(32'd1, 6);
        enable0 = 1'b1; ready0 = 1'b1;
        drain0("seed0");

        // Five-cycle consumer stall mid-stream.
        reseed0(32'h1234_5678, "stall");
        push_base(32'h1234_5678, 16);
        enable0 = 1'b1;
        for (int c = 0; c < 80 && (sb.size() != 0 || c < 11); c++) begin
            if (c >= 6 && c < 11) begin
                ready0 = 1'b0;
                check("stall_hold", {31'd0, valid0, data0[31:0]} ^ {data0[63:32], 32'd0},
                      {31'd0, 1'b1, sb[0][31:0]} ^ {sb[0][63:32], 32'd0});
            end else begin
                ready0 = 1'b1;
            end
            tick();
        end
        drain0("stall");

        // Gaps in enable must not skip or repeat words.
        reseed0(32'hDEAD_BEEF, "engap");
        push_base(32'hDEAD_BEEF, 8);
        ready0 = 1'b1;
        for (int c = 0; c < 100 && sb.size() != 0; c++) begin
            enable0 = en_pat[c % 16];
            tick();
        end
        drain0("engap");

        // 16-bit lane: warm-up length, first word and full period.
        enable1 = 1'b1; ready1 = 1'b1;
        seed1 = 16'hACE1;
        seed_load1 = 1'b1;
        tick();
        seed_load1 = 1'b0;
        check("d1_sl_valid", 64'(valid1), 64'd0);
        busy_count1(n);
        check("d1_busy_cycles", 64'(n), 64'd3);
        wait_valid1("d1_first");
        check("d1_first_word", 64'(data1), 64'(m_emit16(16'h389C)));
        n = 0;
        for (int i = 0; i < 70000; i++) begin
            tick();
            n++;
            if (data1 == m_emit16(16'h389C)) break;
        end
        check("d1_period", 64'(n), 64'd65535);

        // Reseed mid-stream with seed 0 on the 16-bit lane.
        seed1 = 16'h0000;
        seed_load1 = 1'b1;
        tick();
        seed_load1 = 1'b0;
        check("d1_mid_valid", 64'(valid1), 64'd0);
        check("d1_mid_busy", 64'(busy1), 64'd1);
        busy_count1(n);
        check("d1_mid_busy_cycles", 64'(n), 64'd3);
        wait_valid1("d1_mid");
        check("d1_mid_first_word", 64'(data1), 64'(m_emit16(16'h2D00)));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lfsr_prng_stream.md
LFSR_PRNG_STREAM -- requirements
Module: lfsr_prng_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 32, lane word width; legal values 16, 24, 32, 64 only.
REQ-002 SHALL have parameter LANES, default 4, count of independent generator lanes (1..8).
REQ-003 SHALL have parameter WARMUP, default 64, LFSR steps discarded after every seeding (0..1023).
REQ-004 SHALL have port clk, input, 1, clock; all logic on rising edge.
REQ-005 SHALL have port resetn, input, 1; reset is resetn, synchronous, active-low; clock is clk.
REQ-006 SHALL have port seed_load, input, 1, single-cycle request to reseed all lanes.
REQ-007 SHALL have port seed, input, WIDTH, base seed; sampled only when seed_load=1.
REQ-008 SHALL have port enable, input, 1, permits generation of new output words.
REQ-009 SHALL have port out_valid, output, 1, out_data holds a word.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts the word.
REQ-011 SHALL have port out_data, output, LANES*WIDTH; lane k occupies bits [k*WIDTH +: WIDTH].
REQ-012 SHALL have port busy, output, 1, high while in WARMUP.

Function
REQ-013 Each lane SHALL be a right-shifting Galois LFSR: lsb=1 -> (s>>1)^TAPS, else s>>1.
REQ-014 TAPS SHALL be: 16 -> 0xB400; 24 -> 0xE10000; 32 -> 0x80200003; 64 -> 0xD800000000000000.
REQ-015 Lane k seed SHALL be base ^ (k*GOLDEN truncated to WIDTH); GOLDEN = 0x9E3779B97F4A7C15 truncated to WIDTH.
REQ-016 base SHALL be seed, or 1 if seed=0; any lane seed evaluating to 0 SHALL be forced to 1.
REQ-017 FSM SHALL have states WARMUP and RUN; reset and seed_load both enter WARMUP with warm counter 0.
REQ-018 WARMUP SHALL advance all lanes once per cycle regardless of enable, then enter RUN after WARMUP steps; WARMUP=0 SHALL enter RUN on the next cycle.
REQ-019 In RUN, if out_valid=0 and enable=1, SHALL register the current lane states into out_data, set out_valid, and advance the lanes.
REQ-020 In RUN, if out_valid=1 and out_ready=1, SHALL load the next word if enable=1, otherwise clear out_valid.
REQ-021 While out_valid=1 and out_ready=0, out_data and the lane states SHALL hold. No word is skipped or duplicated.
REQ-022 Sustained throughput SHALL be one word per cycle. The first out_valid SHALL occur one cycle after RUN is entered with enable=1.
REQ-023 seed_load SHALL take priority over every other event. Next cycle: out_valid=0, lanes reseeded, busy=1. Any pending word is discarded.

Reset
REQ-024 On resetn=0: lanes load the seeds for base 1, state=WARMUP, warm counter=0, out_valid=0, out_data=0, busy=0.
REQ-025 busy SHALL be 1 from the first cycle after reset release until WARMUP completes.

Configuration
REQ-026 With macro LFSR_PRNG_SCALE_EN defined, the block SHALL add input scale [WIDTH-1:0]. Each emitted lane SHALL be (lane_state*scale)>>WIDTH, uniform in [0,scale), with scale sampled when the word is registered.
REQ-027 Without LFSR_PRNG_SCALE_EN, the scale port and multipliers SHALL be absent and raw lane states emitted.

Structure
REQ-028 Package prng_pkg SHALL hold the TAPS lookup function, the GOLDEN constant, the default seed, and the FSM state enum.
REQ-029 Sub-module lfsr_core SHALL implement one lane (load, step, hold) and be instantiated LANES times.

Verification
REQ-030 WIDTH=32, WARMUP=0, seed_load with seed=1, enable=1, out_ready=1 -> lane0 emits 0x00000001, 0x80200003, 0xC0300002; lane1 first word = 0x9E3779B8.
REQ-031 seed=0 -> identical output stream to seed=1. No lane ever reads 0.
REQ-032 out_ready held low for 5 cycles mid-stream -> out_data stable throughout; after release the sequence continues with no gap against a reference model.
REQ-033 WARMUP=64, seed_load mid-stream -> out_valid=0 next cycle, busy high exactly 64 cycles, first word equals the reference after 64 steps.
REQ-034 WIDTH=16, LANES=1 free-running -> state returns to the seed after exactly 65535 steps and not before.
REQ-035 LFSR_PRNG_SCALE_EN, scale=100, lane state 0x80000000 -> lane output 50; scale=0 -> 0.
